dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - port A: processor load/store path, which stalls on loss.
  - port B: debug/loader master, which preloads or inspects dmem.
- Issues at most one access per cycle and routes read data back to the owner after a fixed memory latency.
- Sits between the processor/loader and the dmem instance, in the dmem clock domain.

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: grants one access per cycle
// and steers read data back to its owner after MEM_LAT cycles.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned PRIO_CPU     = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_stall,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_stall,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic [7:0]        starve_cnt
);

    localparam int unsigned Last = MEM_LAT - 1;
    localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

    logic              rr_ptr_q;  // 0: A wins next contention, 1: B
    logic [7:0]        starve_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [MEM_LAT-1:0] tag_v_q, tag_p_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              a_win, b_win, rd_issue;

    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (reset) begin
            if (a_req && b_req) begin
                if (PRIO_CPU != 0) begin
                    if (starve_cnt_q == StarveMax) b_win = 1'b1;
                    else a_win = 1'b1;
                end else if (rr_ptr_q) begin
                    b_win = 1'b1;
                end else begin
                    a_win = 1'b1;
                end
            end else begin
                a_win = a_req;
                b_win = b_req;
            end
        end
    end

    always_comb begin
        a_gnt    = a_win;
        b_gnt    = b_win;
        a_stall  = a_req & ~a_win;
        b_stall  = b_req & ~b_win;
        mem_wren = (a_win & a_we) | (b_win & b_we);
        rd_issue = (a_win & ~a_we) | (b_win & ~b_we);
        mem_addr = addr_q;
        mem_data = data_q;
        if (b_win) begin
            mem_addr = b_addr;
            mem_data = b_wdata;
        end else if (a_win) begin
            mem_addr = a_addr;
            mem_data = a_wdata;
        end
        // Returning tags are masked while reset is low so pre-reset reads never surface.
        a_rvalid   = reset & tag_v_q[Last] & ~tag_p_q[Last];
        b_rvalid   = reset & tag_v_q[Last] & tag_p_q[Last];
        a_rdata    = a_rvalid ? mem_q : a_rdata_q;
        b_rdata    = b_rvalid ? mem_q : b_rdata_q;
        starve_cnt = starve_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q     <= 1'b0;
            starve_cnt_q <= 8'd0;
            addr_q       <= '0;
            data_q       <= '0;
            tag_v_q      <= '0;
            tag_p_q      <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            if (a_win) rr_ptr_q <= 1'b1;
            else if (b_win) rr_ptr_q <= 1'b0;

            if (PRIO_CPU == 0) starve_cnt_q <= 8'd0;
            else if (b_req && !b_win)
                starve_cnt_q <= (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 8'd1;
            else starve_cnt_q <= 8'd0;

            addr_q     <= mem_addr;
            data_q     <= mem_data;
            tag_v_q[0] <= rd_issue;
            tag_p_q[0] <= b_win;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_p_q[i] <= tag_p_q[i-1];
            end
            a_rdata_q <= a_rdata;
            b_rdata_q <= b_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: dut0 is fixed-priority with MEM_LAT=1, dut1 is round-robin with MEM_LAT=2;
// both share the request stimulus and each drives its own memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [11:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic        a_gnt0, a_stall0, a_rvalid0, b_gnt0, b_stall0, b_rvalid0, wren0;
    logic [31:0] a_rdata0, b_rdata0, wdat0, q0;
    logic [11:0] addr0;
    logic [7:0]  starve0;
    logic        a_gnt1, a_stall1, a_rvalid1, b_gnt1, b_stall1, b_rvalid1, wren1;
    logic [31:0] a_rdata1, b_rdata1, wdat1, q1, q1a;
    logic [11:0] addr1;
    logic [7:0]  starve1;

    logic [31:0] mem0 [0:4095];
    logic [31:0] mem1 [0:4095];

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(1), .PRIO_CPU(1), .STARVE_LIMIT(8)) dut0 (
        .clock(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt0), .a_stall(a_stall0), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt0), .b_stall(b_stall0), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0),
        .mem_addr(addr0), .mem_wren(wren0), .mem_data(wdat0), .mem_q(q0),
        .starve_cnt(starve0)
    );

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(2), .PRIO_CPU(0), .STARVE_LIMIT(8)) dut1 (
        .clock(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt1), .a_stall(a_stall1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt1), .b_stall(b_stall1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .mem_addr(addr1), .mem_wren(wren1), .mem_data(wdat1), .mem_q(q1),
        .starve_cnt(starve1)
    );

    // Synchronous RAM models: read data appears MEM_LAT cycles after the issue edge.
    always @(posedge clk) begin
        if (wren0) mem0[addr0] <= wdat0;
        q0 <= mem0[addr0];
        if (wren1) mem1[addr1] <= wdat1;
        q1a <= mem1[addr1];
        q1  <= q1a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle();
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    endtask

    initial begin
        // Reset held with both ports requesting writes: nothing may be granted.
        reset = 1'b0; a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
        a_addr = 12'h000; b_addr = 12'h000; a_wdata = 32'h0; b_wdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_a_gnt0", {31'b0, a_gnt0}, 32'd0);
            chk("rst_b_gnt0", {31'b0, b_gnt0}, 32'd0);
            chk("rst_wren0", {31'b0, wren0}, 32'd0);
            chk("rst_a_gnt1", {31'b0, a_gnt1}, 32'd0);
            chk("rst_wren1", {31'b0, wren1}, 32'd0);
            next_cycle();
        end
        reset = 1'b1;
        #1;
        chk("rel_starve0", {24'b0, starve0}, 32'd0);
        chk("rel_a_gnt0", {31'b0, a_gnt0}, 32'd1);
        chk("rel_b_gnt0", {31'b0, b_gnt0}, 32'd0);
        chk("rel_a_gnt1", {31'b0, a_gnt1}, 32'd1);
        next_cycle();
        idle();
        next_cycle();

        // B preloads 0x010, then A reads it back.
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h010; b_wdata = 32'hDEADBEEF;
        #1;
        chk("pre_b_gnt0", {31'b0, b_gnt0}, 32'd1);
        chk("pre_wren0", {31'b0, wren0}, 32'd1);
        next_cycle();
        idle();
        a_req = 1'b1; a_addr = 12'h010;
        #1;
        chk("rd_a_gnt0", {31'b0, a_gnt0}, 32'd1);
        chk("rd_addr0", {20'b0, addr0}, 32'h010);
        next_cycle();
        idle();
        #1;
        chk("rd_a_rvalid0", {31'b0, a_rvalid0}, 32'd1);
        chk("rd_a_rdata0", a_rdata0, 32'hDEADBEEF);
        chk("rd_b_rvalid0", {31'b0, b_rvalid0}, 32'd0);
        chk("rd_a_rvalid1_early", {31'b0, a_rvalid1}, 32'd0);
        next_cycle();
        #1;
        chk("rd_a_rvalid0_once", {31'b0, a_rvalid0}, 32'd0);
        chk("rd_a_rdata0_hold", a_rdata0, 32'hDEADBEEF);
        chk("rd_a_rvalid1", {31'b0, a_rvalid1}, 32'd1);
        chk("rd_a_rdata1", a_rdata1, 32'hDEADBEEF);
        next_cycle();

        // Write from B followed immediately by a read of the same word from A.
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h055; b_wdata = 32'h12345678;
        next_cycle();
        idle();
        a_req = 1'b1; a_addr = 12'h055;
        next_cycle();
        idle();
        #1;
        chk("coh_a_rvalid0", {31'b0, a_rvalid0}, 32'd1);
        chk("coh_a_rdata0", a_rdata0, 32'h12345678);
        next_cycle();
        next_cycle();

        // Starvation guard: A writes every cycle, B reads continuously.
        a_req = 1'b1; a_we = 1'b1; a_addr = 12'h030; a_wdata = 32'h5;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h010;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("stv_b_gnt_%0d", k), {31'b0, b_gnt0}, 32'd0);
            next_cycle();
            #1;
            chk($sformatf("stv_cnt_%0d", k), {24'b0, starve0}, k);
        end
        chk("stv_b_gnt_9", {31'b0, b_gnt0}, 32'd1);
        chk("stv_a_stall_9", {31'b0, a_stall0}, 32'd1);
        chk("stv_cnt_9", {24'b0, starve0}, 32'd8);
        next_cycle();
        #1;
        chk("stv_cnt_clr", {24'b0, starve0}, 32'd0);
        chk("stv_b_rvalid0", {31'b0, b_rvalid0}, 32'd1);
        chk("stv_b_rdata0", b_rdata0, 32'hDEADBEEF);
        chk("stv_a_rvalid0", {31'b0, a_rvalid0}, 32'd0);
        chk("rr_starve1", {24'b0, starve1}, 32'd0);
        next_cycle();
        idle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;

        // Round-robin on dut1: A writes 0x100+n, B reads 0x010; grants alternate from A.
        for (int i = 0; i < 8; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 12'h100 + 12'(i / 2); a_wdata = 32'(i / 2);
            b_req = 1'b1; b_we = 1'b0; b_addr = 12'h010;
            #1;
            chk($sformatf("rr_a_gnt_%0d", i), {31'b0, a_gnt1}, {31'b0, (i % 2) == 0});
            chk($sformatf("rr_b_gnt_%0d", i), {31'b0, b_gnt1}, {31'b0, (i % 2) == 1});
            chk($sformatf("rr_addr_%0d", i), {20'b0, addr1},
                ((i % 2) == 0) ? 32'h100 + 32'(i / 2) : 32'h010);
            chk($sformatf("rr_b_rvalid_%0d", i), {31'b0, b_rvalid1},
                {31'b0, (i >= 3) && ((i % 2) == 1)});
            chk($sformatf("rr_a_rvalid_%0d", i), {31'b0, a_rvalid1}, 32'd0);
            next_cycle();
        end
        idle();
        #1;
        chk("hold_addr1", {20'b0, addr1}, 32'h010);
        chk("hold_wren1", {31'b0, wren1}, 32'd0);
        chk("hold_a_gnt1", {31'b0, a_gnt1}, 32'd0);
        next_cycle();
        #1;
        chk("rr_last_b_rvalid", {31'b0, b_rvalid1}, 32'd1);
        chk("rr_last_b_rdata", b_rdata1, 32'hDEADBEEF);
        next_cycle();
        next_cycle();

        // Reset lands the cycle after an A read issues: that read must never return.
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010;
        #1;
        chk("mid_a_gnt1", {31'b0, a_gnt1}, 32'd1);
        next_cycle();
        idle();
        reset = 1'b0;
        #1;
        chk("mid_a_rvalid0_rst", {31'b0, a_rvalid0}, 32'd0);
        next_cycle();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("mid_a_rvalid1_%0d", c), {31'b0, a_rvalid1}, 32'd0);
            chk($sformatf("mid_a_rdata1_%0d", c), a_rdata1, 32'd0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
